// File: rtl/fp_add_sched.sv
// fp_add_sched: shares one external combinational FP adder among N_REQ
// requesters through a two-stage issue/result pipeline with tagged,
// valid/ready-handshaked responses.
// Build option: define FP_ADD_SCHED_RR_EN for round-robin arbitration;
// leave it undefined for fixed priority (lowest index wins).
module fp_add_sched #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ-1:0][31:0] req_a,
    input  logic [N_REQ-1:0][31:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic [31:0]            add_a,
    output logic [31:0]            add_b,
    input  logic [31:0]            add_s,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [31:0]            rsp_sum,
    input  logic                   rsp_ready
);

    // Stage 1 (issue) and stage 2 (result) registers
    logic            s1_v, s2_v;
    logic [31:0]     s1_a, s1_b, s2_sum;
    logic [ID_W-1:0] s1_id, s2_id;

    logic            s2_load, s1_free;
    logic            any_req, hs;
    logic [ID_W-1:0] gnt_idx;
    logic [N_REQ-1:0] gnt_oh;

`ifdef FP_ADD_SCHED_RR_EN
    logic [ID_W-1:0] rr_ptr;
`endif

    // Pipeline advance: stage 2 takes stage 1 whenever it is empty or draining,
    // and stage 1 is free when empty or moving forward this cycle.
    assign s2_load = s1_v & (~s2_v | rsp_ready);
    assign s1_free = ~s1_v | s2_load;

    assign add_a     = s1_a;
    assign add_b     = s1_b;
    assign rsp_valid = s2_v;
    assign rsp_sum   = s2_sum;
    assign rsp_id    = s2_id;

    // Arbiter: pick one requester index, then gate the one-hot grant by s1_free
    always_comb begin
        gnt_idx = '0;
        any_req = |req_valid;
`ifdef FP_ADD_SCHED_RR_EN
        begin
            logic found;
            int   idx;
            found = 1'b0;
            idx   = 0;
            for (int k = 0; k < N_REQ; k++) begin
                idx = (int'(rr_ptr) + k) % N_REQ;
                if (!found && req_valid[idx]) begin
                    found   = 1'b1;
                    gnt_idx = ID_W'(idx);
                end
            end
        end
`else
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[k]) gnt_idx = ID_W'(k);
        end
`endif
        gnt_oh    = N_REQ'(1) << gnt_idx;
        // Grants are suppressed while reset is held so no transfer is implied
        req_ready = (!rst && s1_free && any_req) ? gnt_oh : '0;
        hs        = |(req_valid & req_ready);
    end

    // Stage 1: accept the granted operands, or drain to empty with data held
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v  <= 1'b0;
            s1_a  <= '0;
            s1_b  <= '0;
            s1_id <= '0;
        end else if (s1_free) begin
            s1_v <= hs;
            if (hs) begin
                s1_a  <= req_a[gnt_idx];
                s1_b  <= req_b[gnt_idx];
                s1_id <= gnt_idx;
            end
        end
    end

    // Stage 2: capture the adder output with its tag, or drain on consume
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v   <= 1'b0;
            s2_sum <= '0;
            s2_id  <= '0;
        end else if (s2_load) begin
            s2_v   <= 1'b1;
            s2_sum <= add_s;
            s2_id  <= s1_id;
        end else if (rsp_ready) begin
            s2_v <= 1'b0;
        end
    end

`ifdef FP_ADD_SCHED_RR_EN
    // Round-robin pointer: the index after the last winner gets top priority
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (hs) begin
            rr_ptr <= (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fp_add_sched.sv
// Directed bench for fp_add_sched. The shared adder is stood in for by a stub
// that returns IEEE sums for the spec's float vectors and an integer sum
// otherwise, so every tagged result is recognisable.
module tb_fp_add_sched;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0][31:0] req_a, req_b;
    logic [N_REQ-1:0]       req_ready;
    logic [31:0]            add_a, add_b, add_s;
    logic                   rsp_valid;
    logic [ID_W-1:0]        rsp_id;
    logic [31:0]            rsp_sum;
    logic                   rsp_ready;

    int vectors = 0;
    int miscompares = 0;

    fp_add_sched #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .add_a(add_a), .add_b(add_b), .add_s(add_s),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_ready(rsp_ready)
    );

    always #5 clk = ~clk;

    // Adder stub
    always_comb begin
        if (add_a == 32'h3F800000 && add_b == 32'h40000000)      add_s = 32'h40400000;
        else if (add_a == 32'h3FC00000 && add_b == 32'hBF000000) add_s = 32'h3F800000;
        else                                                      add_s = add_a + add_b;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge (inputs are driven here)
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge, where outputs are sampled
    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;

        // ---- reset state ----
        tick(); tick();
        req_valid = 4'hF;
        mid();
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_id",    32'(rsp_id),    32'h0);
        chk("rst_rsp_sum",   rsp_sum,        32'h0);
        chk("rst_add_a",     add_a,          32'h0);
        chk("rst_add_b",     add_b,          32'h0);
        tick();
        rst = 1'b0; req_valid = '0;

        // ---- single request from requester 2 ----
        tick();
        req_valid = 4'b0100; req_a[2] = 32'h3F800000; req_b[2] = 32'h40000000;
        mid();
        chk("single_grant", 32'(req_ready), 32'h4);
        tick(); req_valid = '0;
        mid();
        chk("single_s1_add_a", add_a, 32'h3F800000);
        chk("single_s1_add_b", add_b, 32'h40000000);
        chk("single_s1_rsp_v", 32'(rsp_valid), 32'h0);
        tick(); mid();
        chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("single_rsp_sum",   rsp_sum,        32'h40400000);
        chk("single_rsp_id",    32'(rsp_id),    32'h2);
        tick(); mid();
        chk("single_drained", 32'(rsp_valid), 32'h0);

        // ---- operand routing, requester 3 ----
        req_valid = 4'b1000; req_a[3] = 32'h3FC00000; req_b[3] = 32'hBF000000;
        mid();
        chk("route_grant", 32'(req_ready), 32'h8);
        tick(); req_valid = '0;
        mid();
        chk("route_add_a", add_a, 32'h3FC00000);
        chk("route_add_b", add_b, 32'hBF000000);
        tick(); mid();
        chk("route_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("route_rsp_sum",   rsp_sum,        32'h3F800000);
        chk("route_rsp_id",    32'(rsp_id),    32'h3);
        tick();

        // ---- backpressure ----
        rsp_ready = 1'b0;
        req_valid = 4'b0001; req_a[0] = 32'h10; req_b[0] = 32'h1;
        mid();
        chk("bp_grant0", 32'(req_ready), 32'h1);
        tick(); req_a[0] = 32'h20; req_b[0] = 32'h2;
        mid();
        chk("bp_grant1", 32'(req_ready), 32'h1);
        tick(); req_a[0] = 32'h30; req_b[0] = 32'h3;
        for (int c = 0; c < 5; c++) begin
            mid();
            chk("bp_req_ready", 32'(req_ready), 32'h0);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_rsp_sum",   rsp_sum,        32'h11);
            chk("bp_rsp_id",    32'(rsp_id),    32'h0);
            tick();
        end
        rsp_ready = 1'b1;
        mid();
        chk("bp_release_grant", 32'(req_ready), 32'h1);
        chk("bp_rel_sum0",      rsp_sum,        32'h11);
        tick(); req_valid = '0;
        mid();
        chk("bp_rel_valid1", 32'(rsp_valid), 32'h1);
        chk("bp_rel_sum1",   rsp_sum,        32'h22);
        tick(); mid();
        chk("bp_rel_valid2", 32'(rsp_valid), 32'h1);
        chk("bp_rel_sum2",   rsp_sum,        32'h33);
        tick(); mid();
        chk("bp_empty", 32'(rsp_valid), 32'h0);

        // ---- reset mid-operation (requester 1 fills both stages) ----
        rsp_ready = 1'b0;
        req_valid = 4'b0010; req_a[1] = 32'h40; req_b[1] = 32'h4;
        tick(); tick();
        req_valid = '0;
        mid();
        chk("mid_full_valid", 32'(rsp_valid), 32'h1);
        tick(); rst = 1'b1;
        mid();
        chk("mid_rst_req_ready", 32'(req_ready), 32'h0);
        tick(); rst = 1'b0;
        mid();
        chk("mid_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("mid_rsp_sum",   rsp_sum,        32'h0);
        chk("mid_add_a",     add_a,          32'h0);
        rsp_ready = 1'b1;
        tick(); mid();
        chk("mid_no_stale1", 32'(rsp_valid), 32'h0);
        tick(); mid();
        chk("mid_no_stale2", 32'(rsp_valid), 32'h0);
        req_valid = 4'b0101; req_a[0] = 32'h50; req_a[2] = 32'h70;
        mid();
        chk("mid_contend_grant", 32'(req_ready), 32'h1);
        tick(); req_valid = '0;
        tick(); tick();

        // Fresh reset so the arbiter starts from index 0
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            req_a[i] = 32'h100 * (i + 1);
            req_b[i] = 32'h0;
        end

`ifdef FP_ADD_SCHED_RR_EN
        // ---- round-robin fairness ----
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            mid();
            chk("rr_grant", 32'(req_ready), 32'h1 << (k % 4));
            if (k >= 2) begin
                chk("rr_rsp_id",  32'(rsp_id), 32'((k - 2) % 4));
                chk("rr_rsp_sum", rsp_sum,     32'h100 * ((k - 2) % 4 + 1));
            end
            tick();
        end
        req_valid = '0;
        for (int k = 8; k < 10; k++) begin
            mid();
            chk("rr_tail_valid", 32'(rsp_valid), 32'h1);
            chk("rr_tail_id",    32'(rsp_id),    32'((k - 2) % 4));
            tick();
        end
`else
        // ---- fixed priority ----
        req_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            mid();
            chk("fp_grant", 32'(req_ready), 32'h2);
            if (k >= 2) chk("fp_rsp_id", 32'(rsp_id), 32'h1);
            tick();
        end
        req_valid = '0;
        for (int k = 0; k < 2; k++) begin
            mid();
            chk("fp_tail_id", 32'(rsp_id), 32'h1);
            tick();
        end
`endif
        mid();
        chk("final_empty", 32'(rsp_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
